// File: rtl/alu.sv
// rtl/alu.sv - two-stage pipelined ALU: clear, logical shift left, signed add, signed subtract
module alu #(
    parameter int DATAW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATAW-1:0]   i_dataa,
    input  logic [DATAW-1:0]   i_datab,
    input  logic [1:0]         i_op,
    output logic [2*DATAW-1:0] o_result
);

    localparam int RW = 2 * DATAW;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_SHL = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    // The shift amount is compared two bits wider so that 2*DATAW is always representable.
    localparam logic [DATAW+1:0] SHIFT_LIMIT = (DATAW + 2)'(RW);

    logic [DATAW-1:0] a_q;
    logic [DATAW-1:0] b_q;
    op_t              op_q;

    logic [RW-1:0]    a_zext;
    logic [RW-1:0]    a_sext;
    logic [RW-1:0]    b_sext;
    logic [DATAW+1:0] b_amount;
    logic [RW-1:0]    shl_value;
    logic [RW-1:0]    add_value;
    logic [RW-1:0]    sub_value;
    logic [RW-1:0]    result_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_CLR;
        end else begin
            a_q  <= i_dataa;
            b_q  <= i_datab;
            op_q <= op_t'(i_op);
        end
    end

    assign a_zext    = {{DATAW{1'b0}}, a_q};
    assign a_sext    = {{DATAW{a_q[DATAW-1]}}, a_q};
    assign b_sext    = {{DATAW{b_q[DATAW-1]}}, b_q};
    assign b_amount  = {2'b00, b_q};
    assign shl_value = (b_amount >= SHIFT_LIMIT) ? '0 : (a_zext << b_q);
    assign add_value = a_sext + b_sext;
    assign sub_value = a_sext - b_sext;

    always_comb begin
        result_next = '0;
        case (op_q)
            OP_CLR:  result_next = '0;
            OP_SHL:  result_next = shl_value;
            OP_ADD:  result_next = add_value;
            OP_SUB:  result_next = sub_value;
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_result <= '0;
        end else begin
            o_result <= result_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu with a delayed arithmetic reference model
module tb_alu;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk;
    logic          rst;
    logic [W-1:0]  dataa;
    logic [W-1:0]  datab;
    logic [1:0]    op;
    logic [RW-1:0] result;

    int tests;
    int fails;
    bit chk_en;

    logic [RW-1:0] exp_s1;
    logic [RW-1:0] exp_s2;

    alu #(.DATAW(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_dataa  (dataa),
        .i_datab  (datab),
        .i_op     (op),
        .o_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] o);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0:    r = 0;
            2'd1:    r = (int'(b) >= RW) ? 0 : (longint'(a) << b);
            2'd2:    r = sa + sb;
            default: r = sa - sb;
        endcase
        return r[RW-1:0];
    endfunction

    // Two-edge delay line of expected results; reset empties it to zeros.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_s1 <= '0;
            exp_s2 <= '0;
        end else begin
            exp_s1 <= ref_op(dataa, datab, op);
            exp_s2 <= exp_s1;
        end
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("model_compare", result, exp_s2);
    end

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] o, input logic [RW-1:0] req);
        @(negedge clk);
        dataa = a;
        datab = b;
        op    = o;
        @(negedge clk);
        @(negedge clk);
        check(name, result, req);
        check({name, "_model"}, exp_s2, req);
    endtask

    logic [W-1:0]  bb_a   [4];
    logic [W-1:0]  bb_b   [4];
    logic [1:0]    bb_op  [4];
    logic [RW-1:0] bb_exp [4];

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        dataa  = 4'b0111;
        datab  = 4'b0111;
        op     = 2'b10;

        #1;
        check("reset_immediate", result, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_held", result, 8'h00);

        rst = 1'b0;
        @(negedge clk);
        check("after_reset_edge1", result, 8'h00);
        @(negedge clk);
        check("after_reset_edge2", result, 8'b00001110);
        chk_en = 1'b1;

        directed("add_7_7",    4'b0111, 4'b0111, 2'b10, 8'b00001110);
        directed("add_m8_m8",  4'b1000, 4'b1000, 2'b10, 8'b11110000);
        directed("add_m1_1",   4'b1111, 4'b0001, 2'b10, 8'b00000000);
        directed("sub_0_1",    4'b0000, 4'b0001, 2'b11, 8'b11111111);
        directed("sub_7_m8",   4'b0111, 4'b1000, 2'b11, 8'b00001111);
        directed("sub_m8_7",   4'b1000, 4'b0111, 2'b11, 8'b11110001);
        directed("shl_f_4",    4'b1111, 4'b0100, 2'b01, 8'b11110000);
        directed("shl_f_5",    4'b1111, 4'b0101, 2'b01, 8'b11100000);
        directed("shl_3_0",    4'b0011, 4'b0000, 2'b01, 8'b00000011);
        directed("shl_f_8",    4'b1111, 4'b1000, 2'b01, 8'b00000000);
        directed("shl_1_7",    4'b0001, 4'b0111, 2'b01, 8'b10000000);
        directed("clr",        4'b1010, 4'b0101, 2'b00, 8'b00000000);

        bb_a[0] = 4'd3; bb_b[0] = 4'd4; bb_op[0] = 2'b10; bb_exp[0] = 8'b00000111;
        bb_a[1] = 4'd3; bb_b[1] = 4'd4; bb_op[1] = 2'b11; bb_exp[1] = 8'b11111111;
        bb_a[2] = 4'd3; bb_b[2] = 4'd2; bb_op[2] = 2'b01; bb_exp[2] = 8'b00001100;
        bb_a[3] = 4'd3; bb_b[3] = 4'd4; bb_op[3] = 2'b00; bb_exp[3] = 8'b00000000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) check($sformatf("back_to_back_%0d", i - 2), result, bb_exp[i-2]);
            if (i < 4) begin
                dataa = bb_a[i];
                datab = bb_b[i];
                op    = bb_op[i];
            end
        end

        // Reset in the middle of a stream of nonzero results.
        directed("pre_reset_add", 4'b0111, 4'b0111, 2'b10, 8'b00001110);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_immediate", result, 8'h00);
        repeat (2) @(negedge clk);
        check("mid_reset_held", result, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_release_edge1", result, 8'h00);
        @(negedge clk);
        check("mid_reset_release_edge2", result, 8'b00001110);

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            dataa = W'($urandom);
            datab = W'($urandom);
            op    = 2'($urandom);
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
